// File: rtl/ex_muldiv_unit_if.sv
// Handshake between the ID/EX pipeline register and the iterative RV32M mul/div unit.
interface ex_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, op_a, op_b, kill,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, op_a, op_b, kill,
      output busy, done, result
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, fixed 34-cycle occupancy of EX.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   ex_muldiv_unit_if.slave mdu
);
   // state | meaning
   // IDLE  | waiting for a valid mul/div op in ID/EX
   // BUSY  | one multiply/divide iteration per cycle, cnt = iteration index
   // DONE  | result presented with done for one cycle
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

   state_t            state, state_nxt;
   logic [5:0]        cnt;
   logic [2:0]        f3_q;
   logic              sgn_a_q, sgn_b_q;
   logic [XLEN-1:0]   opnd_q;
   logic [2*XLEN-1:0] acc;
   logic              spec_q;
   logic [XLEN-1:0]   spec_val_q;
   logic [XLEN-1:0]   result_q;

   logic              accept, busy_c, done_c;
   logic              signed_a, signed_b, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              spec_c;
   logic [XLEN-1:0]   spec_val_c;
   logic [XLEN:0]     mul_sum, div_rem_sh, div_diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, final_val;

   always_comb begin
      signed_a   = (mdu.funct3 != 3'b011) && (mdu.funct3 != 3'b101) && (mdu.funct3 != 3'b111);
      signed_b   = signed_a && (mdu.funct3 != 3'b010);
      neg_a      = signed_a & mdu.op_a[XLEN-1];
      neg_b      = signed_b & mdu.op_b[XLEN-1];
      mag_a      = neg_a ? -mdu.op_a : mdu.op_a;
      mag_b      = neg_b ? -mdu.op_b : mdu.op_b;
      spec_c     = 1'b0;
      spec_val_c = '0;
      if (mdu.funct3[2] && (mdu.op_b == '0)) begin
         spec_c     = 1'b1;
         spec_val_c = mdu.funct3[1] ? mdu.op_a : '1;
      end else if (signed_b && mdu.funct3[2] && (mdu.op_b == '1) &&
                   (mdu.op_a == {1'b1, {(XLEN-1){1'b0}}})) begin
         // signed overflow: quotient saturates to the dividend, remainder is zero
         spec_c     = 1'b1;
         spec_val_c = mdu.funct3[1] ? '0 : mdu.op_a;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            if (mdu.start && !mdu.kill) begin
               accept    = 1'b1;
               busy_c    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            busy_c = 1'b1;
            if (mdu.kill)                state_nxt = IDLE;
            else if (cnt == LAST_ITER)   state_nxt = DONE;
         end
         DONE: begin
            done_c    = !mdu.kill;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // acc holds {partial product high, multiplier} or {partial remainder, dividend/quotient}
   always_comb begin
      mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd_q : {XLEN{1'b0}})};
      div_rem_sh = acc[2*XLEN-1:XLEN-1];
      div_diff   = div_rem_sh - {1'b0, opnd_q};
   end

   always_comb begin
      prod = (sgn_a_q ^ sgn_b_q) ? -acc : acc;
      quo  = (sgn_a_q ^ sgn_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = sgn_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (f3_q)
         3'b000:                 final_val = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_val = quo;
         default:                final_val = rem;
      endcase
      if (spec_q) final_val = spec_val_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         f3_q       <= '0;
         sgn_a_q    <= 1'b0;
         sgn_b_q    <= 1'b0;
         opnd_q     <= '0;
         acc        <= '0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         result_q   <= '0;
      end else begin
         if (accept) begin
            cnt        <= '0;
            f3_q       <= mdu.funct3;
            sgn_a_q    <= neg_a;
            sgn_b_q    <= neg_b;
            opnd_q     <= mdu.funct3[2] ? mag_b : mag_a;
            acc        <= {{XLEN{1'b0}}, (mdu.funct3[2] ? mag_a : mag_b)};
            spec_q     <= spec_c;
            spec_val_q <= spec_val_c;
         end else if (state == BUSY) begin
            cnt <= cnt + 6'd1;
            if (!f3_q[2])
               acc <= {mul_sum, acc[XLEN-1:1]};
            else if (!div_diff[XLEN])
               acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
               acc <= {div_rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
         if (done_c) result_q <= final_val;
      end
   end

   assign mdu.busy   = busy_c;
   assign mdu.done   = done_c;
   assign mdu.result = done_c ? final_val : result_q;
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It is fed directly from the ID/EX pipeline register outputs. While an M-extension instruction is computing, it asserts `busy`, which drives the stall input of the ID/EX register and the stages upstream of it. When the computation finishes, it presents a 32-bit result to the EX/MEM path for exactly one cycle.

## Interface

**Parameters**
- `XLEN`, default 32: operand and result width. Only 32 is supported.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: the ID/EX entry is valid and is a mul/div op. Held high by the stalled ID/EX register until `done`.
- `funct3`, in, 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`, in, XLEN: rs1 value (forwarded).
- `op_b`, in, XLEN: rs2 value (forwarded).
- `kill`, in, 1: abort the in-flight op (flush from an older event).
- `busy`, out, 1: stall request to ID/EX and upstream.
- `done`, out, 1: one-cycle pulse; `result` is valid this cycle.
- `result`, out, XLEN: final value. Registered and held until the next `done`.

## Operation

**States**
- IDLE
- BUSY: 32 iterations, tracked by a 6-bit counter `cnt`.
- DONE

**IDLE**
- `start` = 1 and `kill` = 0: capture `funct3`, operand magnitudes, and sign flags; clear the accumulator; `cnt` ← 0; go to BUSY.
- `start` ignored when `kill` = 1.

**BUSY**
- Performs one iteration per cycle.
- Goes to DONE after the iteration with `cnt` = 31.

**DONE**
- Drives `done` = 1 and `result`.
- Returns to IDLE unconditionally.
- `start` is ignored in this cycle because the same instruction is still in ID/EX.

**Multiply**
- Unsigned shift-add on the magnitudes, producing a 64-bit product.
- Sign of the operands by op:
  - MUL: both signed.
  - MULH: both signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU: both unsigned.
- The 64-bit product is negated if the operand signs differ.
- MUL returns bits [31:0]; the other three return bits [63:32].

**Divide**
- Unsigned restoring division on the magnitudes, one quotient bit per cycle.
- Signed ops:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.

**Special cases** (computed at capture and applied at DONE; latency unchanged)
- Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `op_a`.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.

**Outputs**
- `busy` = (IDLE & `start` & !`kill`) | BUSY. It is combinational so that the ID/EX register holds in the start cycle.

**Kill**
- In BUSY or DONE: next state is IDLE.
- If `kill` coincides with DONE, `done` is suppressed that cycle and `result` is not updated.

**Reset**
- Has priority over `kill` and `start`.
- State IDLE, `cnt` = 0, `busy` = 0 (given `start` = 0), `done` = 0, `result` = 0, accumulators = 0.

## Timing

- Start accepted in cycle T (IDLE, `start` = 1).
- BUSY for cycles T+1 through T+32.
- DONE in cycle T+33.
- `busy` is high in cycles T through T+32 and low in T+33.
- The ID/EX register advances at the end of T+33, so the instruction spends 34 cycles in EX.
- Latency is fixed for all eight ops and all operand values.
- Back-to-back mul/div: the next instruction reaches ID/EX at T+34 while the unit is in IDLE, so it starts with no extra bubble.
- `kill` asserted at cycle K in BUSY: unit is in IDLE at K+1 with `busy` low; no `done`.
- Reset asserted mid-op: all outputs at reset values in the next cycle.

## Test plan

- MUL, `op_a` = 7, `op_b` = 0xFFFFFFFD:
  - `busy` high for exactly 33 cycles;
  - `done` at T+33 with `result` = 0xFFFFFFEB.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division edge cases:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Back-to-back DIVU 100/7 then MUL 3×4:
  - `done` pulses at T+33 (`result` 14) and at T+67 (`result` 12);
  - `start` held high during DONE causes no restart.
- Kill and reset mid-operation:
  - `kill` at T+10 → IDLE at T+11, no `done`, `result` unchanged.
  - `reset` at T+20 → `done` = 0 and `result` = 0 at T+21.
- Randomized: 10k ops over all `funct3` values checked against a reference model, with random `kill` injection.
